// File: rtl/syzygy_adc_frame_align.sv
// -----------------------------------------------------------------------------
// syzygy_adc_frame_align
//
// Purpose:
//   Frame-clock based word alignment for a SYZYGY ADC ISERDES front end.
//   The parallel frame word is compared against the expected frame pattern.
//   On a mismatch during the search, a single bitslip pulse goes to every
//   ISERDES (frame and data lanes), then the block waits for the deserialisers
//   to settle before it looks again. After enough consecutive matches the
//   block locks and qualifies the data path. Repeated misses while locked
//   drop the lock and restart the search. If every bit position has been
//   tried without success, the search gives up and stays in FAIL.
//
// Ports:
//   clk          in   divided SERDES clock (single clock domain)
//   reset_n      in   asynchronous active-low reset
//   realign      in   single-cycle request to restart alignment
//   frame_word   in   [SER_WIDTH] parallel frame-clock word
//   data_in      in   [CHANNELS*SER_WIDTH] parallel data words, lane 0 in LSBs
//   bitslip      out  bitslip pulse broadcast to all ISERDES
//   data_out     out  [CHANNELS*SER_WIDTH] data_in registered once
//   data_valid   out  data_out is frame-aligned
//   aligned      out  state is LOCKED
//   align_fail   out  search exhausted (sticky until realign/reset)
//   slip_count   out  [8] bitslips issued since the last search start
//   dbg_state    out  [3] current FSM state (SEARCH=0, SLIP=1, SETTLE=2,
//                     LOCKED=3, FAIL=4)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module syzygy_adc_frame_align #(
    parameter int          CHANNELS      = 2,
    parameter int          SER_WIDTH     = 8,
    parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
    parameter int          MATCH_COUNT   = 8,
    parameter int          LOSS_COUNT    = 4,
    parameter int          SETTLE        = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            realign,
    input  logic [SER_WIDTH-1:0]            frame_word,
    input  logic [CHANNELS*SER_WIDTH-1:0]   data_in,
    output logic                            bitslip,
    output logic [CHANNELS*SER_WIDTH-1:0]   data_out,
    output logic                            data_valid,
    output logic                            aligned,
    output logic                            align_fail,
    output logic [7:0]                      slip_count,
    output logic [2:0]                      dbg_state
);

    typedef enum logic [2:0] {
        ST_SEARCH = 3'd0,
        ST_SLIP   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    localparam logic [SER_WIDTH-1:0] PATTERN     = FRAME_PATTERN[SER_WIDTH-1:0];
    localparam logic [7:0]           MATCH_LAST  = 8'(MATCH_COUNT - 1);
    localparam logic [7:0]           LOSS_LAST   = 8'(LOSS_COUNT - 1);
    localparam logic [7:0]           SETTLE_LAST = 8'(SETTLE - 1);
    // Once every bit position of the word has been visited twice, give up.
    localparam logic [7:0]           SLIP_LIMIT  = 8'(2 * SER_WIDTH);

    state_t                          state_q, state_d;
    logic [7:0]                      match_cnt_q, match_cnt_d;
    logic [7:0]                      loss_cnt_q, loss_cnt_d;
    logic [7:0]                      settle_cnt_q, settle_cnt_d;
    logic [7:0]                      slip_cnt_q, slip_cnt_d;
    logic [CHANNELS*SER_WIDTH-1:0]   data_q;

    logic is_match;
    assign is_match = (frame_word == PATTERN);

    // -------------------------------------------------------------------------
    // State and counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_SEARCH;
            match_cnt_q  <= 8'd0;
            loss_cnt_q   <= 8'd0;
            settle_cnt_q <= 8'd0;
            slip_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            match_cnt_q  <= match_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
        end
    end

    // Data path: one register stage in every state, independent of the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_in;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        match_cnt_d  = match_cnt_q;
        loss_cnt_d   = loss_cnt_q;
        settle_cnt_d = settle_cnt_q;
        slip_cnt_d   = slip_cnt_q;

        if (realign) begin
            // Restart from scratch; any slip/settle in flight is dropped.
            state_d      = ST_SEARCH;
            match_cnt_d  = 8'd0;
            loss_cnt_d   = 8'd0;
            settle_cnt_d = 8'd0;
            slip_cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (is_match) begin
                        if (match_cnt_q == MATCH_LAST) begin
                            state_d     = ST_LOCKED;
                            match_cnt_d = 8'd0;
                        end else begin
                            match_cnt_d = match_cnt_q + 8'd1;
                        end
                    end else begin
                        match_cnt_d = 8'd0;
                        state_d     = (slip_cnt_q == SLIP_LIMIT) ? ST_FAIL : ST_SLIP;
                    end
                end
                ST_SLIP: begin
                    if (slip_cnt_q != 8'hFF) begin
                        slip_cnt_d = slip_cnt_q + 8'd1;
                    end
                    settle_cnt_d = 8'd0;
                    state_d      = ST_SETTLE;
                end
                ST_SETTLE: begin
                    // frame_word is ignored while the ISERDES output settles.
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_d = 8'd0;
                        state_d      = ST_SEARCH;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    if (is_match) begin
                        loss_cnt_d = 8'd0;
                    end else if (loss_cnt_q == LOSS_LAST) begin
                        state_d     = ST_SEARCH;
                        loss_cnt_d  = 8'd0;
                        match_cnt_d = 8'd0;
                        slip_cnt_d  = 8'd0;
                    end else begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs decode straight from the registered state, so reset removes a
    // bitslip pulse immediately and no output depends combinationally on
    // the inputs.
    // -------------------------------------------------------------------------
    assign bitslip    = (state_q == ST_SLIP);
    assign aligned    = (state_q == ST_LOCKED);
    assign data_valid = (state_q == ST_LOCKED);
    assign align_fail = (state_q == ST_FAIL);
    assign slip_count = slip_cnt_q;
    assign data_out   = data_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_syzygy_adc_frame_align.sv
`timescale 1ns/1ps

module tb_syzygy_adc_frame_align;

  localparam int         CH    = 2;
  localparam int         SW    = 8;
  localparam int         CH2   = 4;
  localparam int         SW2   = 4;
  localparam int         MATCH = 8;
  localparam int         LOSS  = 4;
  localparam int         SET   = 4;
  localparam logic [7:0] PAT   = 8'hF0;

  localparam int M_SEARCH = 0;
  localparam int M_SLIP   = 1;
  localparam int M_SETTLE = 2;
  localparam int M_LOCKED = 3;
  localparam int M_FAIL   = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_n;
  logic                 realign;
  logic [SW-1:0]        frame_word;
  logic [CH*SW-1:0]     data_in;
  logic                 bitslip;
  logic [CH*SW-1:0]     data_out;
  logic                 data_valid;
  logic                 aligned;
  logic                 align_fail;
  logic [7:0]           slip_count;
  logic [2:0]           dbg_state;

  logic                 realign2;
  logic [SW2-1:0]       frame_word2;
  logic [CH2*SW2-1:0]   data_in2;
  logic                 bitslip2;
  logic [CH2*SW2-1:0]   data_out2;
  logic                 data_valid2;
  logic                 aligned2;
  logic                 align_fail2;
  logic [7:0]           slip_count2;
  logic [2:0]           dbg_state2;

  syzygy_adc_frame_align u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .realign    (realign),
    .frame_word (frame_word),
    .data_in    (data_in),
    .bitslip    (bitslip),
    .data_out   (data_out),
    .data_valid (data_valid),
    .aligned    (aligned),
    .align_fail (align_fail),
    .slip_count (slip_count),
    .dbg_state  (dbg_state)
  );

  syzygy_adc_frame_align #(
    .CHANNELS  (CH2),
    .SER_WIDTH (SW2)
  ) u_dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .realign    (realign2),
    .frame_word (frame_word2),
    .data_in    (data_in2),
    .bitslip    (bitslip2),
    .data_out   (data_out2),
    .data_valid (data_valid2),
    .aligned    (aligned2),
    .align_fail (align_fail2),
    .slip_count (slip_count2),
    .dbg_state  (dbg_state2)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: alignment search described as a mode plus a few
  // counts (consecutive matches, consecutive misses, slips so far, settle
  // time remaining), stepped once per rising edge.
  // ---------------------------------------------------------------------------
  int   m_mode;
  int   m_run;
  int   m_miss;
  int   m_slips;
  int   m_wait;
  int   m2_edges;
  bit   model_live;
  logic [CH*SW-1:0]   exp_q[$];
  logic [CH2*SW2-1:0] exp2_q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode     = M_SEARCH;
      m_run      = 0;
      m_miss     = 0;
      m_slips    = 0;
      m_wait     = 0;
      m2_edges   = 0;
      model_live = 1'b0;
      exp_q.delete();
      exp2_q.delete();
    end else begin
      exp_q.push_back(data_in);
      exp2_q.push_back(data_in2);
      model_live = 1'b1;
      if (m2_edges < 100000) m2_edges++;
      if (realign) begin
        m_mode  = M_SEARCH;
        m_run   = 0;
        m_miss  = 0;
        m_slips = 0;
        m_wait  = 0;
      end else begin
        case (m_mode)
          M_SEARCH: begin
            if (frame_word == PAT) begin
              m_run++;
              if (m_run == MATCH) begin
                m_mode = M_LOCKED;
                m_run  = 0;
              end
            end else begin
              m_run  = 0;
              m_mode = (m_slips == 2 * SW) ? M_FAIL : M_SLIP;
            end
          end
          M_SLIP: begin
            if (m_slips < 255) m_slips++;
            m_wait = SET;
            m_mode = M_SETTLE;
          end
          M_SETTLE: begin
            m_wait--;
            if (m_wait == 0) m_mode = M_SEARCH;
          end
          M_LOCKED: begin
            if (frame_word == PAT) begin
              m_miss = 0;
            end else begin
              m_miss++;
              if (m_miss == LOSS) begin
                m_mode  = M_SEARCH;
                m_miss  = 0;
                m_run   = 0;
                m_slips = 0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: compare every cycle on the falling edge.
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int last_pulse = -1;
  int pulse_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) last_pulse = -1;
    if (reset_n && model_live) begin
      check("data_out", data_out, exp_q.pop_front());
      check("bitslip", bitslip, (m_mode == M_SLIP));
      check("aligned", aligned, (m_mode == M_LOCKED));
      check("data_valid", data_valid, (m_mode == M_LOCKED));
      check("align_fail", align_fail, (m_mode == M_FAIL));
      check("slip_count", slip_count, m_slips);
      check("data_out4", data_out2, exp2_q.pop_front());
      check("data_valid4", data_valid2, aligned2);
      check("aligned4", aligned2, (m2_edges >= MATCH));
      if (bitslip) begin
        if (last_pulse >= 0) check("pulse_spacing", ((cyc - last_pulse) >= SET + 2), 1);
        last_pulse = cyc;
        pulse_cyc.push_back(cyc);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  bit rot_mode = 1'b0;
  int rot_off  = 0;

  function automatic logic [7:0] rotr(input logic [7:0] v, input int k);
    logic [7:0] r;
    r = (v >> k) | (v << (8 - k));
    return r;
  endfunction

  // Advance exactly one rising edge; inputs change 1ns after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
    if (rot_mode) begin
      if (bitslip) rot_off = (rot_off + 7) % 8;
      frame_word = rotr(PAT, rot_off);
    end
    data_in  = 16'($urandom);
    data_in2 = 16'($urandom);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_bitslip", bitslip, 0);
    check("rst_aligned", aligned, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_align_fail", align_fail, 0);
    check("rst_slip_count", slip_count, 0);
    check("rst_data_out", data_out, 0);
    check("rst_data_out4", data_out2, 0);
    check("rst_state", dbg_state, 0);
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  int p0;
  int n;

  initial begin
    reset_n     = 1'b1;
    realign     = 1'b0;
    realign2    = 1'b0;
    frame_word  = PAT;
    frame_word2 = '0;
    data_in     = '0;
    data_in2    = '0;
    #2;

    // Constant correct frame from reset: lock after 8 edges, no slips.
    do_reset();
    p0 = pulse_cyc.size();
    repeat (7) step();
    check("A_not_locked_at_7", aligned, 0);
    step();
    check("A_locked_at_8", aligned, 1);
    check("A_data_valid", data_valid, 1);
    check("A_slip_count", slip_count, 0);
    check("A_no_pulses", pulse_cyc.size() - p0, 0);

    // Frame rotated by 3, source rotates one bit per bitslip.
    rot_mode   = 1'b1;
    rot_off    = 3;
    frame_word = rotr(PAT, 3);
    do_reset();
    p0 = pulse_cyc.size();
    n  = 0;
    while (!aligned && n < 200) begin
      step();
      n++;
    end
    check("B_locked", aligned, 1);
    check("B_lock_edges", n, 26);
    check("B_pulses", pulse_cyc.size() - p0, 3);
    check("B_slip_count", slip_count, 3);
    if (pulse_cyc.size() >= p0 + 3) begin
      check("B_gap1", pulse_cyc[p0 + 1] - pulse_cyc[p0], 6);
      check("B_gap2", pulse_cyc[p0 + 2] - pulse_cyc[p0 + 1], 6);
    end
    rot_mode = 1'b0;

    // Frame never matches: 16 slips then sticky FAIL.
    frame_word = 8'h00;
    do_reset();
    p0 = pulse_cyc.size();
    n  = 0;
    while (!align_fail && n < 300) begin
      step();
      n++;
    end
    check("C_fail", align_fail, 1);
    check("C_fail_edges", n, 97);
    check("C_pulses", pulse_cyc.size() - p0, 16);
    check("C_slip_count", slip_count, 16);
    repeat (20) step();
    check("C_fail_sticky", align_fail, 1);
    check("C_no_more_pulses", pulse_cyc.size() - p0, 16);

    // realign while in FAIL.
    realign = 1'b1;
    step();
    realign = 1'b0;
    check("D_state_search", dbg_state, 0);
    check("D_align_fail", align_fail, 0);
    check("D_slip_count", slip_count, 0);
    check("D_bitslip", bitslip, 0);
    frame_word = PAT;
    p0 = pulse_cyc.size();
    repeat (3) step();
    check("D_no_pulse_on_match", pulse_cyc.size() - p0, 0);
    frame_word = 8'h00;
    step();
    check("D_pulse_on_mismatch", bitslip, 1);

    // realign while in SETTLE.
    step();
    step();
    check("E_in_settle", dbg_state, 2);
    check("E_slip_count_1", slip_count, 1);
    realign = 1'b1;
    step();
    realign = 1'b0;
    check("E_state_search", dbg_state, 0);
    check("E_slip_count", slip_count, 0);
    check("E_bitslip", bitslip, 0);
    frame_word = PAT;
    p0 = pulse_cyc.size();
    repeat (3) step();
    check("E_no_pulse", pulse_cyc.size() - p0, 0);

    // Lock, then 3 misses, 1 match, 4 misses.
    repeat (5) step();
    check("F_locked", aligned, 1);
    frame_word = 8'h00;
    repeat (3) step();
    check("F_held_after_3", aligned, 1);
    frame_word = PAT;
    step();
    check("F_held_after_match", aligned, 1);
    frame_word = 8'h00;
    repeat (3) step();
    check("F_held_after_3b", aligned, 1);
    step();
    check("F_dropped", aligned, 0);
    check("F_data_valid", data_valid, 0);
    check("F_state_search", dbg_state, 0);
    check("F_slip_count", slip_count, 0);

    // Reset in the middle of a bitslip pulse.
    step();
    check("G_in_slip", bitslip, 1);
    do_reset();

    repeat (10) step();
    check("H_aligned4", aligned2, 1);
    check("H_state4_locked", dbg_state2, 3);
    check("H_no_slip4", slip_count2, 0);
    check("H_no_fail4", align_fail2, 0);
    check("H_no_bitslip4", bitslip2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
